bram_m20k_fifo_ctrl: RTL

Stream FIFO controller that turns one simple-dual-port M20K brick (1-cycle registered read, no read enable on output hold semantics relied upon) into a valid/ready first-word-fall-through FIFO. Sits between a producer stage of the SpMV merge pipeline and its consumer. It owns both brick ports: it drives write port and read port, captures brick read data, and holds it in a 2-entry output skid buffer so the consumer sees registered data and full throughput.

---
 rtl/bram_m20k_fifo_ctrl_if.sv | 41 ++++
 rtl/bram_m20k_fifo_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/bram_m20k_fifo_ctrl_if.sv
// Stream and brick port bundle for the M20K-backed FWFT FIFO controller.
// The master side is the environment (producer, consumer and the brick itself);
// the slave side is the controller.

`ifndef LIM_BRICK_WORD_SIZE
`define LIM_BRICK_WORD_SIZE 32
`endif
`ifndef BITS_ADDR_LIM_BRICK
`define BITS_ADDR_LIM_BRICK 9
`endif

interface bram_m20k_fifo_ctrl_if #(
    parameter int BL_WIDTH   = `LIM_BRICK_WORD_SIZE,
    parameter int ADDR_WIDTH = `BITS_ADDR_LIM_BRICK
);
    logic                  in_valid;
    logic [BL_WIDTH-1:0]   in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [BL_WIDTH-1:0]   out_data;
    logic                  out_ready;
    logic [ADDR_WIDTH+1:0] count;
    logic                  bram_wr_en;
    logic [ADDR_WIDTH-1:0] bram_wr_addr;
    logic [BL_WIDTH-1:0]   bram_WBL;
    logic                  bram_rd_en;
    logic [ADDR_WIDTH-1:0] bram_rd_addr;
    logic [BL_WIDTH-1:0]   bram_ARBL;

    modport master (
        output in_valid, in_data, out_ready, bram_ARBL,
        input  in_ready, out_valid, out_data, count,
               bram_wr_en, bram_wr_addr, bram_WBL, bram_rd_en, bram_rd_addr
    );

    modport slave (
        input  in_valid, in_data, out_ready, bram_ARBL,
        output in_ready, out_valid, out_data, count,
               bram_wr_en, bram_wr_addr, bram_WBL, bram_rd_en, bram_rd_addr
    );
endinterface

// File: rtl/bram_m20k_fifo_ctrl.sv
// First-word-fall-through valid/ready FIFO built around one simple-dual-port
// M20K brick with a registered 1-cycle read. Brick reads are pre-fetched into a
// 2-entry skid buffer so the consumer sees registered data at full throughput.

`ifndef LIM_BRICK_WORD_SIZE
`define LIM_BRICK_WORD_SIZE 32
`endif
`ifndef BITS_ADDR_LIM_BRICK
`define BITS_ADDR_LIM_BRICK 9
`endif

module bram_m20k_fifo_ctrl #(
    parameter int BL_WIDTH   = `LIM_BRICK_WORD_SIZE,
    parameter int ADDR_WIDTH = `BITS_ADDR_LIM_BRICK
) (
    input logic                    CLK,
    input logic                    rst,
    bram_m20k_fifo_ctrl_if.slave   bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CW-1:0]         bram_cnt;
    logic                  rd_pending;
    logic [1:0]            skid_cnt;
    logic [BL_WIDTH-1:0]   skid0;
    logic [BL_WIDTH-1:0]   skid1;

    logic                  in_ready_int;
    logic                  out_valid_int;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            skid_after;
    logic [1:0]            cap_pos;
    logic [ADDR_WIDTH+1:0] count_sum;

    // Handshake decode and read-issue decision; a read is issued only when the
    // skid buffer plus the in-flight read still leaves room after this cycle's pop.
    always_comb begin
        in_ready_int  = (bram_cnt != DEPTH) && !rst;
        out_valid_int = (skid_cnt != 2'd0) && !rst;
        push          = bus.in_valid && in_ready_int;
        pop           = out_valid_int && bus.out_ready;
        skid_after    = {1'b0, skid_cnt} + {2'b00, rd_pending} - {2'b00, pop};
        issue         = (bram_cnt != '0) && (skid_after < 3'd2) && !rst;
        cap_pos       = skid_cnt - {1'b0, pop};
        count_sum     = {1'b0, bram_cnt}
                      + {{(ADDR_WIDTH+1){1'b0}}, rd_pending}
                      + {{ADDR_WIDTH{1'b0}}, skid_cnt};
    end

    assign bus.in_ready     = in_ready_int;
    assign bus.out_valid    = out_valid_int;
    assign bus.out_data     = skid0;
    assign bus.count        = rst ? '0 : count_sum;
    assign bus.bram_wr_en   = push;
    assign bus.bram_wr_addr = wptr;
    assign bus.bram_WBL     = bus.in_data;
    assign bus.bram_rd_en   = issue;
    assign bus.bram_rd_addr = rptr;

    // Pointers and occupancy counters; reset discards every held and in-flight word.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            bram_cnt   <= '0;
            rd_pending <= 1'b0;
            skid_cnt   <= 2'd0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (issue)
                rptr <= rptr + 1'b1;
            bram_cnt   <= bram_cnt + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, issue};
            rd_pending <= issue;
            skid_cnt   <= skid_after[1:0];
        end
    end

    // Skid data: a pop shifts the tail forward, and returning brick data lands in
    // the first free slot after that shift, which keeps words in order.
    always_ff @(posedge CLK) begin
        if (pop)
            skid0 <= skid1;
        if (rd_pending) begin
            if (cap_pos == 2'd0)
                skid0 <= bus.bram_ARBL;
            else
                skid1 <= bus.bram_ARBL;
        end
    end
endmodule
